// File: rtl/ysyx_22051013_ifu_fq.sv
// rtl/ysyx_22051013_ifu_fq.sv - fetch unit with decoupling instruction queue
//
// Owns the architectural fetch PC, issues one instruction-memory request at a
// time and buffers returned {pc, inst} pairs in a DEPTH-entry FIFO that drains
// to ID. EX/ID redirects override the BPU prediction and flush the queue plus
// any in-flight response.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_pc_jump / ex_pc_i          EX redirect request and target (wins)
//   id_pc_jump / id_pc_i          ID redirect request and target
//   fetch_pc_o / bpu_pc_i         current fetch PC to BPU, predicted successor
//   imem_req_valid/ready/addr     instruction memory request channel
//   imem_rsp_valid/inst           instruction memory response
//   if_valid/if_pc/if_inst        queue head presented to ID
//   id_ready                      ID consumes the head entry
//   fq_count                      number of occupied queue entries

module ysyx_22051013_ifu_fq #(
  parameter int              PC_W     = 64,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_pc_jump,
  input  logic [PC_W-1:0]          ex_pc_i,
  input  logic                     id_pc_jump,
  input  logic [PC_W-1:0]          id_pc_i,
  output logic [PC_W-1:0]          fetch_pc_o,
  input  logic [PC_W-1:0]          bpu_pc_i,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [PC_W-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [INST_W-1:0]        imem_rsp_inst,
  output logic                     if_valid,
  output logic [PC_W-1:0]          if_pc,
  output logic [INST_W-1:0]        if_inst,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]   pc_r;
  logic [PC_W-1:0]   req_pc_r;
  logic              outstanding;
  logic              discard;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [PC_W-1:0]   q_pc   [DEPTH];
  logic [INST_W-1:0] q_inst [DEPTH];

  logic              redirect;
  logic [PC_W-1:0]   target;
  logic              req_fire;
  logic              rsp_take;
  logic              push;
  logic              pop;

  assign redirect = ex_pc_jump | id_pc_jump;
  assign target   = ex_pc_jump ? ex_pc_i : id_pc_i;

  // Issue is blocked while a response is owed (kept or to be discarded), so the
  // slot a pending response will fill is always reserved in the queue.
  assign imem_req_valid = !rst && !outstanding && !discard && !redirect &&
                          (count < CNT_W'(DEPTH));
  assign imem_req_addr  = pc_r;
  assign fetch_pc_o     = pc_r;

  assign req_fire = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding (e.g. left over from before a reset)
  // are ignored entirely.
  assign rsp_take = outstanding && imem_rsp_valid;
  assign push     = rsp_take && !discard && !redirect;
  assign pop      = (count != '0) && id_ready && !redirect;

  assign if_valid = (count != '0);
  assign if_pc    = q_pc[rd_ptr];
  assign if_inst  = q_inst[rd_ptr];
  assign fq_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      req_pc_r    <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      if (redirect) begin
        pc_r <= target;
      end else if (req_fire) begin
        pc_r <= bpu_pc_i;
      end

      if (req_fire) begin
        req_pc_r <= pc_r;
      end

      if (req_fire) begin
        outstanding <= 1'b1;
      end else if (rsp_take) begin
        outstanding <= 1'b0;
      end

      // A redirect with the response still pending means the response, when it
      // finally comes, belongs to the abandoned path.
      if (rsp_take) begin
        discard <= 1'b0;
      end else if (redirect && outstanding) begin
        discard <= 1'b1;
      end

      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc[wr_ptr]   <= req_pc_r;
      q_inst[wr_ptr] <= imem_rsp_inst;
    end
  end

endmodule
